// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell (two half adders plus a carry
// flop) stepped LSB-first across WIDTH-bit operands, with a start/busy/done handshake.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             last;
   logic             h1_s, h1_c, h2_c, s_bit, c_bit;

   // first half adder takes the operand bits, second folds in the carry
   assign h1_s  = a_reg[0] ^ b_reg[0];
   assign h1_c  = a_reg[0] & b_reg[0];
   assign s_bit = h1_s ^ carry;
   assign h2_c  = h1_s & carry;
   assign c_bit = h1_c | h2_c;

   assign last = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg   <= '0;
         b_reg   <= '0;
         sum_reg <= '0;
         carry   <= 1'b0;
         cnt     <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               a_reg   <= a;
               b_reg   <= b;
               carry   <= cin;
               sum_reg <= '0;
               cnt     <= '0;
            end
            RUN: begin
               // result bits arrive LSB-first and enter at the top
               sum_reg <= {s_bit, sum_reg[WIDTH-1:1]};
               a_reg   <= a_reg >> 1;
               b_reg   <= b_reg >> 1;
               carry   <= c_bit;
               cnt     <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);
   assign sum  = sum_reg;
   assign cout = carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized and directed bench for serial_add_ctrl against an arithmetic a+b+cin model.
module tb_serial_add_ctrl;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst, start, cin;
   logic [W-1:0] a, b;
   logic         busy, done, cout;
   logic [W-1:0] sum;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   // observations collected by launch
   int           o_busy, o_done_n, o_both, o_done_cyc;
   logic [W-1:0] o_sum;
   logic         o_cout;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   // Pulse start from a negedge and watch until done (bounded). mode 1 pulses a
   // competing start mid-run, mode 2 changes the operands mid-run.
   task automatic launch(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic, input int mode);
      a = ia; b = ib; cin = ic; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      o_busy = 0; o_done_n = 0; o_both = 0; o_done_cyc = 0;
      o_sum = 'x; o_cout = 1'bx;
      for (int n = 1; n <= W + 6 && o_done_n == 0; n++) begin
         @(negedge clk);
         if (busy) o_busy++;
         if (busy && done) o_both++;
         if (done) begin
            o_done_n = n; o_sum = sum; o_cout = cout; o_done_cyc = cyc;
         end
         if (mode == 1 && n == 3) begin a = '1; b = '1; cin = 1'b1; start = 1'b1; end
         if (mode == 1 && n == 4) start = 1'b0;
         if (mode == 2 && n == 2) begin a = '1; b = '1; cin = 1'b1; end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (2) @(negedge clk);
      compared++;
      if ({busy, done, cout, sum} !== '0) begin
         mismatched++;
         $display("FAIL reset_outputs: got busy=%b done=%b cout=%b sum=%h want all 0", busy, done, cout, sum);
      end
      rst = 1'b0;
      @(negedge clk);
      compared++;
      if ({busy, done, cout, sum} !== '0) begin
         mismatched++;
         $display("FAIL post_reset_outputs: got busy=%b done=%b cout=%b sum=%h want all 0", busy, done, cout, sum);
      end
   endtask

   task automatic test_idle_hold();
      for (int i = 0; i < 20; i++) begin
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
         @(negedge clk);
         compared++;
         if ({busy, done, cout, sum} !== '0) begin
            mismatched++;
            $display("FAIL idle_hold[%0d]: got busy=%b done=%b cout=%b sum=%h want all 0", i, busy, done, cout, sum);
         end
      end
   endtask

   task automatic test_adds();
      logic [W-1:0] va [3] = '{8'h3C, 8'hFF, 8'hA5};
      logic [W-1:0] vb [3] = '{8'h0F, 8'h01, 8'h5A};
      logic         vc [3] = '{1'b0, 1'b0, 1'b1};
      logic [W-1:0] es [3] = '{8'h4B, 8'h00, 8'h00};
      logic         ec [3] = '{1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         launch(va[i], vb[i], vc[i], 0);
         compared++;
         if (o_sum !== es[i] || o_cout !== ec[i]) begin
            mismatched++;
            $display("FAIL add[%0d]: got sum=%h cout=%b want sum=%h cout=%b", i, o_sum, o_cout, es[i], ec[i]);
         end
         compared++;
         if (o_done_n !== W + 1) begin
            mismatched++;
            $display("FAIL add_latency[%0d]: got %0d want %0d", i, o_done_n, W + 1);
         end
         compared++;
         if (o_busy !== W || o_both !== 0) begin
            mismatched++;
            $display("FAIL add_busy[%0d]: got busy_cycles=%0d overlap=%0d want %0d and 0", i, o_busy, o_both, W);
         end
      end
   endtask

   task automatic test_start_while_busy();
      @(negedge clk);
      launch(8'h10, 8'h20, 1'b0, 1);
      compared++;
      if (o_sum !== 8'h30 || o_cout !== 1'b0 || o_done_n !== W + 1) begin
         mismatched++;
         $display("FAIL busy_start: got sum=%h cout=%b done_at=%0d want 30 0 %0d", o_sum, o_cout, o_done_n, W + 1);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         compared++;
         if ({busy, done, cout, sum} !== {2'b00, 1'b0, 8'h30}) begin
            mismatched++;
            $display("FAIL busy_start_after[%0d]: got busy=%b done=%b cout=%b sum=%h want 0 0 0 30", i, busy, done, cout, sum);
         end
      end
   endtask

   task automatic test_operand_change();
      @(negedge clk);
      launch(8'h01, 8'h01, 1'b0, 2);
      compared++;
      if (o_sum !== 8'h02 || o_cout !== 1'b0) begin
         mismatched++;
         $display("FAIL operand_change: got sum=%h cout=%b want 02 0", o_sum, o_cout);
      end
   endtask

   task automatic test_reset_mid_run();
      @(negedge clk);
      a = 8'hFF; b = 8'h00; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      compared++;
      if (busy !== 1'b1 || sum === '0) begin
         mismatched++;
         $display("FAIL mid_run_state: got busy=%b sum=%h want busy=1 sum nonzero", busy, sum);
      end
      #2 rst = 1'b1;
      #1;
      compared++;
      if ({busy, done, cout, sum} !== '0) begin
         mismatched++;
         $display("FAIL async_reset: got busy=%b done=%b cout=%b sum=%h want all 0", busy, done, cout, sum);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         compared++;
         if ({busy, done, cout, sum} !== '0) begin
            mismatched++;
            $display("FAIL reset_stay[%0d]: got busy=%b done=%b cout=%b sum=%h want all 0", i, busy, done, cout, sum);
         end
      end
      launch(8'h7F, 8'h01, 1'b0, 0);
      compared++;
      if (o_sum !== 8'h80 || o_cout !== 1'b0 || o_done_n !== W + 1) begin
         mismatched++;
         $display("FAIL after_reset_add: got sum=%h cout=%b done_at=%0d want 80 0 %0d", o_sum, o_cout, o_done_n, W + 1);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] ia, ib;
      logic         ic;
      logic [W:0]   exp;
      int           prev;
      prev = -1;
      @(negedge clk);
      for (int i = 0; i < 200; i++) begin
         ia = W'($urandom); ib = W'($urandom); ic = 1'($urandom);
         exp = {1'b0, ia} + {1'b0, ib} + (W + 1)'(ic);
         launch(ia, ib, ic, 0);
         compared++;
         if ({o_cout, o_sum} !== exp || o_done_n !== W + 1) begin
            mismatched++;
            $display("FAIL b2b[%0d]: %h+%h+%b got cout=%b sum=%h done_at=%0d want cout=%b sum=%h done_at=%0d",
                     i, ia, ib, ic, o_cout, o_sum, o_done_n, exp[W], exp[W-1:0], W + 1);
         end
         if (prev >= 0) begin
            compared++;
            if (o_done_cyc - prev !== W + 2) begin
               mismatched++;
               $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, o_done_cyc - prev, W + 2);
            end
         end
         prev = o_done_cyc;
         // first IDLE cycle after done; next start is driven right here
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_idle_hold();
      test_adds();
      test_start_while_busy();
      test_operand_change();
      test_reset_mid_run();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
